// File: rtl/adder_datapath_checker_if.sv
// Bus between the adder datapath checker and its environment: run control, the
// operands and result of the adder under test, and the run status.
interface adder_datapath_checker_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [15:0]      num_vectors;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      error_count;
    logic [15:0]      first_err_index;

    modport master (
        input  start, num_vectors, y,
        output a, b, c, busy, done, pass, error_count, first_err_index
    );

    modport slave (
        output start, num_vectors, y,
        input  a, b, c, busy, done, pass, error_count, first_err_index
    );
endinterface

// File: rtl/adder_datapath_checker.sv
// Drives directed and LFSR operand vectors into a three-operand adder, predicts each sum
// and checks the adder result after LATENCY cycles, counting and locating mismatches.
module adder_datapath_checker #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    adder_datapath_checker_if.master  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [15:0] LfsrMask  = 16'hB400;
    localparam logic [15:0] SeedA     = 16'hACE1;
    localparam logic [15:0] SeedB     = 16'h1D0F;
    localparam logic [15:0] SeedC     = 16'h5A5A;
    localparam logic [15:0] NoIndex   = 16'hFFFF;
    localparam logic [3:0]  DrainLast = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ LfsrMask) : (x >> 1);
    endfunction

    state_e           state_q, state_d;
    logic [15:0]      n_q, n_d;
    logic [15:0]      idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [15:0]      la_q, la_d, lb_q, lb_d, lc_q, lc_d;
    logic [3:0]       drain_q, drain_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      first_q, first_d;
    logic             busy_q, done_q, pass_q;

    // A vector is on a/b/c exactly during RUN cycles.
    logic             issue_valid;
    logic [WIDTH-1:0] issue_sum;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_sum;
    logic [15:0]      chk_idx;
    logic             mismatch;

    assign issue_valid = (state_q == StRun);
    assign issue_sum   = a_q + b_q + c_q;

    if (LATENCY == 0) begin : g_nopipe
        assign chk_valid = issue_valid;
        assign chk_sum   = issue_sum;
        assign chk_idx   = idx_q;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_q;
        logic [WIDTH-1:0]   sum_q [LATENCY];
        logic [15:0]        pidx_q[LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= issue_valid;
                for (int unsigned k = 1; k < LATENCY; k++) vld_q[k] <= vld_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            sum_q[0]  <= issue_sum;
            pidx_q[0] <= idx_q;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                sum_q[k]  <= sum_q[k-1];
                pidx_q[k] <= pidx_q[k-1];
            end
        end

        assign chk_valid = vld_q[LATENCY-1];
        assign chk_sum   = sum_q[LATENCY-1];
        assign chk_idx   = pidx_q[LATENCY-1];
    end

    assign mismatch = chk_valid && (bus.y != chk_sum);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        a_d     = '0;
        b_d     = '0;
        c_d     = '0;
        la_d    = la_q;
        lb_d    = lb_q;
        lc_d    = lc_q;
        drain_d = drain_q;
        err_d   = err_q;
        first_d = first_q;

        if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (first_q == NoIndex) first_d = chk_idx;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    err_d   = '0;
                    first_d = NoIndex;
                    n_d     = bus.num_vectors;
                    idx_d   = '0;
                    if (bus.num_vectors == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        a_d     = '1;
                        b_d     = '1;
                        c_d     = '1;
                        la_d    = SeedA;
                        lb_d    = SeedB;
                        lc_d    = SeedC;
                    end
                end
            end
            StRun: begin
                if (idx_q == n_q - 16'd1) begin
                    drain_d = '0;
                    state_d = (LATENCY == 0) ? StDone : StDrain;
                end else begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == 16'd0) begin
                        a_d = {{(WIDTH-1){1'b0}}, 1'b1};
                        b_d = '1;
                        c_d = '0;
                    end else begin
                        a_d  = WIDTH'(la_q);
                        b_d  = WIDTH'(lb_q);
                        c_d  = WIDTH'(lc_q);
                        la_d = lfsr_step(la_q);
                        lb_d = lfsr_step(lb_q);
                        lc_d = lfsr_step(lc_q);
                    end
                end
            end
            StDrain: begin
                // Holds until the last vector's result has left the delay line.
                if (drain_q == DrainLast) state_d = StDone;
                else drain_d = drain_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            la_q    <= SeedA;
            lb_q    <= SeedB;
            lc_q    <= SeedC;
            drain_q <= '0;
            err_q   <= '0;
            first_q <= NoIndex;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            lc_q    <= lc_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            first_q <= first_d;
            busy_q  <= (state_d == StRun) || (state_d == StDrain);
            done_q  <= (state_d == StDone);
            pass_q  <= (state_d == StDone) && (err_d == 16'd0);
        end
    end

    assign bus.a               = a_q;
    assign bus.b               = b_q;
    assign bus.c               = c_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.error_count     = err_q;
    assign bus.first_err_index = first_q;
endmodule

// File: tb/tb_adder_datapath_checker.sv
// Directed bench: a LATENCY=2 checker against a registered (or combinational) adder model
// and a LATENCY=0 checker against a combinational adder, sharing start/num_vectors.
module tb_adder_datapath_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num;
    logic        inject;
    logic        comb_mode;
    int          cyc;
    int          checks = 0;
    int          failures = 0;

    int          done_cyc2, done_cyc0, busy_first, busy_last;
    logic [15:0] obs_a[16], obs_b[16], obs_c[16], obs_s[16];

    always #5 clk = ~clk;

    adder_datapath_checker_if #(.WIDTH(16)) bus2 ();
    adder_datapath_checker_if #(.WIDTH(16)) bus0 ();

    adder_datapath_checker #(.WIDTH(16), .LATENCY(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    adder_datapath_checker #(.WIDTH(16), .LATENCY(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    // Two-stage registered adder; optional bit-0 flip on the results of vectors 5 and 7.
    logic [15:0] s1, s2;
    logic        flip;
    always_ff @(posedge clk) begin
        s1 <= bus2.a + bus2.b + bus2.c;
        s2 <= s1;
    end
    assign flip = inject && (cyc == 8 || cyc == 10);

    assign bus2.start       = start;
    assign bus2.num_vectors = num;
    assign bus2.y           = comb_mode ? (bus2.a + bus2.b + bus2.c) : (s2 ^ {15'd0, flip});
    assign bus0.start       = start;
    assign bus0.num_vectors = num;
    assign bus0.y           = bus0.a + bus0.b + bus0.c;

    // Start a run with n vectors, optionally pulse start again at cycle pulse_at (0 = never).
    task automatic run(input logic [15:0] n, input int pulse_at);
        done_cyc2  = -1;
        done_cyc0  = -1;
        busy_first = -1;
        busy_last  = -1;
        @(negedge clk);
        start = 1'b1;
        num   = n;
        cyc   = 0;
        while ((done_cyc2 < 0 || done_cyc0 < 0) && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
            if (cyc < 16) begin
                obs_a[cyc] = bus2.a;
                obs_b[cyc] = bus2.b;
                obs_c[cyc] = bus2.c;
                obs_s[cyc] = bus2.a + bus2.b + bus2.c;
            end
            if (bus2.busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (done_cyc2 < 0 && bus2.done) done_cyc2 = cyc;
            if (done_cyc0 < 0 && bus0.done) done_cyc0 = cyc;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num = '0; inject = 1'b0; comb_mode = 1'b0; cyc = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus2.a !== 16'h0 || bus2.b !== 16'h0 || bus2.c !== 16'h0) begin
            failures++; $display("FAIL reset_abc: got %h %h %h want 0 0 0", bus2.a, bus2.b, bus2.c); end
        checks++; if ({bus2.busy, bus2.done, bus2.pass} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b want 000", {bus2.busy, bus2.done, bus2.pass}); end
        checks++; if (bus2.error_count !== 16'h0 || bus2.first_err_index !== 16'hFFFF) begin
            failures++; $display("FAIL reset_counts: got %h %h want 0000 ffff", bus2.error_count,
                                 bus2.first_err_index); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        run(16'd10, 0);
        checks++; if (obs_a[1] !== 16'hFFFF || obs_b[1] !== 16'hFFFF || obs_c[1] !== 16'hFFFF) begin
            failures++; $display("FAIL vec0: got %h %h %h want ffff x3", obs_a[1], obs_b[1], obs_c[1]); end
        checks++; if (obs_s[1] !== 16'hFFFD) begin
            failures++; $display("FAIL vec0_sum: got %h want fffd", obs_s[1]); end
        checks++; if (obs_a[2] !== 16'h0001 || obs_b[2] !== 16'hFFFF || obs_c[2] !== 16'h0000) begin
            failures++; $display("FAIL vec1: got %h %h %h want 0001 ffff 0000", obs_a[2], obs_b[2],
                                 obs_c[2]); end
        checks++; if (obs_s[2] !== 16'h0000) begin
            failures++; $display("FAIL vec1_sum: got %h want 0000", obs_s[2]); end
        checks++; if (obs_a[3] !== 16'hACE1 || obs_b[3] !== 16'h1D0F || obs_c[3] !== 16'h5A5A) begin
            failures++; $display("FAIL vec2_seeds: got %h %h %h want ace1 1d0f 5a5a", obs_a[3],
                                 obs_b[3], obs_c[3]); end
        checks++; if (obs_a[4] !== 16'hE270 || obs_b[4] !== 16'hBA87 || obs_c[4] !== 16'h2D2D) begin
            failures++; $display("FAIL vec3_step: got %h %h %h want e270 ba87 2d2d", obs_a[4],
                                 obs_b[4], obs_c[4]); end
        checks++; if (obs_a[12] !== 16'h0 || obs_a[11] !== 16'h0) begin
            failures++; $display("FAIL drain_abc: got %h %h want 0 0", obs_a[11], obs_a[12]); end
        checks++; if (done_cyc2 != 13) begin
            failures++; $display("FAIL loop_done_cycle: got %0d want 13", done_cyc2); end
        checks++; if (busy_first != 1 || busy_last != 12) begin
            failures++; $display("FAIL loop_busy_window: got %0d..%0d want 1..12", busy_first,
                                 busy_last); end
        checks++; if (bus2.pass !== 1'b1 || bus2.error_count !== 16'h0
                      || bus2.first_err_index !== 16'hFFFF) begin
            failures++; $display("FAIL loop_result: got pass=%b err=%h first=%h want 1 0000 ffff",
                                 bus2.pass, bus2.error_count, bus2.first_err_index); end
    endtask

    task automatic test_inject();
        inject = 1'b1;
        run(16'd10, 0);
        inject = 1'b0;
        checks++; if (bus2.error_count !== 16'd2 || bus2.first_err_index !== 16'd5
                      || bus2.pass !== 1'b0) begin
            failures++; $display("FAIL inject: got err=%h first=%h pass=%b want 0002 0005 0",
                                 bus2.error_count, bus2.first_err_index, bus2.pass); end
    endtask

    task automatic test_zero();
        run(16'd0, 0);
        checks++; if (done_cyc2 != 1 || busy_first != -1) begin
            failures++; $display("FAIL zero_timing: got done=%0d busy=%0d want 1 -1", done_cyc2,
                                 busy_first); end
        checks++; if (bus2.pass !== 1'b1 || bus2.error_count !== 16'h0) begin
            failures++; $display("FAIL zero_result: got pass=%b err=%h want 1 0000", bus2.pass,
                                 bus2.error_count); end
    endtask

    task automatic test_start_ignored();
        inject = 1'b1;
        run(16'd10, 3);
        inject = 1'b0;
        checks++; if (done_cyc2 != 13) begin
            failures++; $display("FAIL ignored_done_cycle: got %0d want 13", done_cyc2); end
        checks++; if (bus2.error_count !== 16'd2 || bus2.first_err_index !== 16'd5) begin
            failures++; $display("FAIL ignored_result: got err=%h first=%h want 0002 0005",
                                 bus2.error_count, bus2.first_err_index); end
    endtask

    task automatic test_restart();
        run(16'd2, 0);
        checks++; if (obs_a[1] !== 16'hFFFF || done_cyc2 != 5) begin
            failures++; $display("FAIL restart_vec0: got a=%h done=%0d want ffff 5", obs_a[1],
                                 done_cyc2); end
        checks++; if (bus2.error_count !== 16'h0 || bus2.first_err_index !== 16'hFFFF
                      || bus2.pass !== 1'b1) begin
            failures++; $display("FAIL restart_cleared: got err=%h first=%h pass=%b want 0 ffff 1",
                                 bus2.error_count, bus2.first_err_index, bus2.pass); end
    endtask

    task automatic test_comb();
        comb_mode = 1'b1;
        run(16'd4, 0);
        comb_mode = 1'b0;
        checks++; if (done_cyc0 != 5 || bus0.pass !== 1'b1) begin
            failures++; $display("FAIL lat0_comb: got done=%0d pass=%b want 5 1", done_cyc0,
                                 bus0.pass); end
        checks++; if (bus2.pass !== 1'b0 || bus2.first_err_index !== 16'd0
                      || bus2.error_count !== 16'd4) begin
            failures++; $display("FAIL lat2_comb: got pass=%b first=%h err=%h want 0 0000 0004",
                                 bus2.pass, bus2.first_err_index, bus2.error_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; num = 16'd10; cyc = 0; inject = 1'b1;
        while (cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
        end
        checks++; if (bus2.busy !== 1'b1) begin
            failures++; $display("FAIL mid_busy: got %b want 1", bus2.busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus2.a !== 16'h0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0
                      || bus2.pass !== 1'b0) begin
            failures++; $display("FAIL mid_async: got a=%h busy=%b done=%b pass=%b want 0 0 0 0",
                                 bus2.a, bus2.busy, bus2.done, bus2.pass); end
        checks++; if (bus2.error_count !== 16'h0 || bus2.first_err_index !== 16'hFFFF) begin
            failures++; $display("FAIL mid_counts: got %h %h want 0000 ffff", bus2.error_count,
                                 bus2.first_err_index); end
        inject = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.a !== 16'h0) begin
            failures++; $display("FAIL mid_idle: got busy=%b done=%b a=%h want 0 0 0", bus2.busy,
                                 bus2.done, bus2.a); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_inject();
        test_zero();
        test_start_ignored();
        test_restart();
        test_comb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
